// File: rtl/pulse_sched_ctrl.sv
// pulse_sched_ctrl: command FIFO and run sequencer for time_ctrl start/WAIT_REG.
// Optional busy-handshake timeout: define PULSE_SCHED_TIMEOUT_EN.
module pulse_sched_ctrl #(
  parameter int B       = 8,
  parameter int RW      = 8,
  parameter int GW      = 16,
  parameter int FIFO_AW = 3,
  parameter int TMO     = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [GW+RW+B-1:0] s_cmd_tdata,
  input  logic              s_cmd_tvalid,
  output logic              s_cmd_tready,
  input  logic              en,
  input  logic              abort,
  output logic              tc_start,
  input  logic              tc_busy,
  output logic [B-1:0]      tc_wait,
  output logic              done,
  output logic              idle,
  output logic              err,
  output logic [FIFO_AW:0]  fifo_cnt
);
  localparam int DEPTH = 2**FIFO_AW;
  localparam int CW    = GW+RW+B;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_RUN, S_GAP, S_FLUSH
  } state_t;

  state_t             r_state;
  logic [CW-1:0]      r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wp;
  logic [FIFO_AW-1:0] r_rp;
  logic [FIFO_AW:0]   r_cnt;
  logic               r_rdy;
  logic [RW-1:0]      r_rep;
  logic [GW-1:0]      r_gap;
  logic [GW-1:0]      r_gcnt;
  logic               r_fcnt;
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic [CW-1:0]      w_head;
  logic [GW-1:0]      w_gap_in;
  logic [GW-1:0]      w_gap_lat;

  assign w_full       = r_cnt == (FIFO_AW+1)'(DEPTH);
  assign w_empty      = r_cnt == '0;
  assign s_cmd_tready = r_rdy & !w_full & !abort;
  assign w_push       = s_cmd_tvalid & s_cmd_tready;
  assign w_pop        = (r_state == S_LOAD) & !abort;
  assign w_head       = r_mem[r_rp];
  assign w_gap_in     = w_head[CW-1 -: GW];
  assign w_gap_lat    = (w_gap_in < GW'(2)) ? GW'(2) : w_gap_in;
  assign fifo_cnt     = r_cnt;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= s_cmd_tdata;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      r_rdy <= 1'b0;
    end else begin
      r_rdy <= 1'b1;
      if (abort) begin
        r_wp  <= '0;
        r_rp  <= '0;
        r_cnt <= '0;
      end else begin
        if (w_push) r_wp <= r_wp + FIFO_AW'(1);
        if (w_pop)  r_rp <= r_rp + FIFO_AW'(1);
        case ({w_push, w_pop})
          2'b10:   r_cnt <= r_cnt + (FIFO_AW+1)'(1);
          2'b01:   r_cnt <= r_cnt - (FIFO_AW+1)'(1);
          default: r_cnt <= r_cnt;
        endcase
      end
    end
  end

`ifdef PULSE_SCHED_TIMEOUT_EN
  localparam int TCW = $clog2(TMO+1);
  logic [TCW-1:0] r_tcnt;
  logic           r_err;
  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state  <= S_IDLE;
      tc_start <= 1'b0;
      tc_wait  <= '0;
      done     <= 1'b0;
      idle     <= 1'b1;
      r_rep    <= '0;
      r_gap    <= '0;
      r_gcnt   <= '0;
      r_fcnt   <= 1'b0;
`ifdef PULSE_SCHED_TIMEOUT_EN
      r_tcnt   <= '0;
      r_err    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef PULSE_SCHED_TIMEOUT_EN
      if (r_state != S_START) r_tcnt <= '0;
`endif
      if (abort) begin
        if (r_state != S_FLUSH) r_fcnt <= 1'b0;
        r_state  <= S_FLUSH;
        tc_start <= 1'b0;
        idle     <= 1'b0;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (en & !w_empty) begin
              r_state <= S_LOAD;
              idle    <= 1'b0;
            end
          end
          S_LOAD: begin
            tc_wait  <= w_head[B-1:0];
            r_rep    <= w_head[B +: RW];
            r_gap    <= w_gap_lat;
            tc_start <= 1'b1;
            r_state  <= S_START;
          end
          S_START: begin
            if (tc_busy) r_state <= S_RUN;
`ifdef PULSE_SCHED_TIMEOUT_EN
            else if (r_tcnt == TCW'(TMO-1)) begin
              r_err    <= 1'b1;
              tc_start <= 1'b0;
              r_fcnt   <= 1'b0;
              r_state  <= S_FLUSH;
            end else r_tcnt <= r_tcnt + TCW'(1);
`endif
          end
          S_RUN: begin
            if (!tc_busy) begin
              tc_start <= 1'b0;
              r_gcnt   <= r_gap - GW'(1);
              r_state  <= S_GAP;
            end
          end
          // start stays low for exactly r_gap cycles between runs
          S_GAP: begin
            if (r_gcnt != '0) r_gcnt <= r_gcnt - GW'(1);
            else if (r_rep != '0) begin
              r_rep    <= r_rep - RW'(1);
              tc_start <= 1'b1;
              r_state  <= S_START;
            end else begin
              done <= 1'b1;
              if (en & !w_empty) r_state <= S_LOAD;
              else begin
                r_state <= S_IDLE;
                idle    <= 1'b1;
              end
            end
          end
          S_FLUSH: begin
            if (tc_busy) r_fcnt <= 1'b0;
            else if (r_fcnt) begin
              r_state <= S_IDLE;
              idle    <= 1'b1;
            end else r_fcnt <= 1'b1;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end
endmodule
